// File: rtl/audio_mix_feeder.sv
// Stereo-to-mono mixer with volume scaling, feeding a frame-paced sample FIFO for a PWM stage.
// Build option: define AUDIO_UNDERRUN_MUTE_EN to emit midscale on underrun (default holds last sample).
module audio_mix_feeder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FRAME_LEN  = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    input  logic [3:0]  volume,
    output logic [15:0] sample_out,
    output logic        frame_tick,
    output logic        underrun
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam int unsigned FRM_W = $clog2(FRAME_LEN);
    localparam logic [15:0] MIDSCALE = 16'h8000;

    // Pipeline state
    logic               accept;
    logic [16:0]        sum;
    logic [15:0]        mix_d;
    logic               s1_valid_q;
    logic [15:0]        s1_mix_q;
    logic [5:0]         gain;
    logic signed [19:0] product;
    logic [15:0]        scaled;
    logic               s2_valid_q;
    logic [15:0]        s2_data_q;

    // FIFO state
    logic [15:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [OCC_W-1:0]   occupancy;
    logic               push;
    logic               pop;
    logic               fifo_empty;

    // Frame timing
    logic [FRM_W-1:0]   frm_q;
    logic               frame_end;

    // Samples still in the pipeline count against capacity so a stage-2 write always has room.
    assign occupancy = OCC_W'(count_q) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);
    assign in_ready  = occupancy < OCC_W'(FIFO_DEPTH);
    assign accept    = in_valid && in_ready;

    always_comb begin
        sum     = {in_left[15], in_left} + {in_right[15], in_right};
        mix_d   = 16'(sum >> 1);
        gain    = {2'b00, volume} + 6'd1;
        product = $signed({{4{s1_mix_q[15]}}, s1_mix_q}) * $signed({14'd0, gain});
        scaled  = 16'(product >> 4);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mix_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_mix_q <= mix_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= {~scaled[15], scaled[14:0]};
            end
        end
    end

    assign fifo_empty = (count_q == '0);
    assign frame_end  = (frm_q == FRM_W'(FRAME_LEN - 1));
    assign push       = s2_valid_q;
    // Empty test uses registered count, so a same-cycle stage-2 write waits for the next frame.
    assign pop        = frame_end && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s2_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_q      <= '0;
            sample_out <= MIDSCALE;
            frame_tick <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frm_q      <= frame_end ? '0 : frm_q + FRM_W'(1);
            frame_tick <= frame_end;
            underrun   <= frame_end && fifo_empty;
            if (pop) begin
                sample_out <= mem_q[rd_ptr_q];
`ifdef AUDIO_UNDERRUN_MUTE_EN
            end else if (frame_end) begin
                sample_out <= MIDSCALE;
`endif
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) occupancy <= OCC_W'(FIFO_DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n) underrun |-> frame_tick);
    assert property (@(posedge clk) disable iff (!rst_n) push |-> (count_q < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_audio_mix_feeder.sv
// Scoreboard bench for audio_mix_feeder: driver queues expected samples, negedge monitor checks.
`timescale 1ns/1ps
module tb_audio_mix_feeder;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FRAME_LEN  = 512;
`ifdef AUDIO_UNDERRUN_MUTE_EN
    localparam logic [15:0] UNDER_OUT = 16'h8000;
`else
    localparam logic [15:0] UNDER_OUT = 16'hC000;
`endif

    typedef struct {
        logic [15:0] val;
        int          k;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic [3:0]  volume;
    logic [15:0] sample_out;
    logic        frame_tick;
    logic        underrun;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rst_cyc = 0;
    bit          started = 0;
    item_t       sb[$];
    logic [15:0] exp_out = 16'h8000;
    int          pos;
    bit          exp_tick;
    bit          exp_under;

    audio_mix_feeder #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_left   (in_left),
        .in_right  (in_right),
        .volume    (volume),
        .sample_out(sample_out),
        .frame_tick(frame_tick),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // Reference: average the channels, scale by (vol+1)/16 with floor, shift to offset binary.
    function automatic logic [15:0] model_out(input logic [15:0] l, input logic [15:0] r,
                                              input logic [3:0] vol);
        int li, ri, mix, sc;
        li  = int'($signed(l));
        ri  = int'($signed(r));
        mix = floor_div(li + ri, 2);
        sc  = floor_div(mix * (int'(vol) + 1), 16);
        return 16'(sc + 32768);
    endfunction

    // A sample accepted in cycle k can be popped at the boundary decided in cycle k+3 or later.
    always @(negedge clk) begin
        if (!rst_n) begin
            started = 1;
            sb.delete();
            exp_out = 16'h8000;
            rst_cyc = cyc + 1;
        end else if (started) begin
            pos       = (cyc - rst_cyc) % int'(FRAME_LEN);
            exp_tick  = (pos == 0) && (cyc != rst_cyc);
            exp_under = 0;
            if (exp_tick) begin
                if (sb.size() > 0 && sb[0].k <= cyc - 4) begin
                    exp_out = sb[0].val;
                    void'(sb.pop_front());
                end else begin
                    exp_under = 1;
`ifdef AUDIO_UNDERRUN_MUTE_EN
                    exp_out = 16'h8000;
`endif
                end
            end
            chk("mon_frame_tick", 32'(frame_tick), 32'(exp_tick));
            chk("mon_underrun", 32'(underrun), 32'(exp_under));
            chk("mon_sample_out", 32'(sample_out), 32'(exp_out));
            chk("mon_in_ready", 32'(in_ready), 32'(sb.size() < int'(FIFO_DEPTH)));
        end
    end

    task automatic drive(input logic v, input logic [15:0] l, input logic [15:0] r,
                         output bit acc);
        logic rdy;
        int   kk;
        in_valid = v;
        in_left  = l;
        in_right = r;
        @(negedge clk);
        rdy = in_ready;
        kk  = cyc;
        @(posedge clk);
        acc = v && rdy && rst_n;
        if (acc) sb.push_back('{val: model_out(l, r, volume), k: kk});
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, acc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < int'(FRAME_LEN) + 2; i++) begin
            if (((cyc - rst_cyc) % int'(FRAME_LEN)) == p) break;
            idle(1);
        end
    endtask

    // Leaves the caller at the negedge of the frame_tick cycle.
    task automatic seek_tick(input string name, output bit seen);
        seen     = 0;
        in_valid = 1'b0;
        for (int i = 0; i < int'(FRAME_LEN) + 8; i++) begin
            if (i != 0) step();
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic expect_tick(input string name, input logic exp_u, input logic [15:0] exp_v);
        bit seen;
        seek_tick(name, seen);
        if (seen) begin
            chk({name, "_underrun"}, 32'(underrun), 32'(exp_u));
            chk({name, "_sample"}, 32'(sample_out), 32'(exp_v));
        end
        step();
        @(negedge clk);
        chk({name, "_tick_width"}, 32'(frame_tick), 32'd0);
        step();
    endtask

    initial begin
        bit acc;
        bit seen;
        int n_acc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        volume   = 4'd15;
        step();
        do_reset(2);
        @(negedge clk);
        chk("reset_sample", 32'(sample_out), 32'h8000);
        chk("reset_tick", 32'(frame_tick), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd1);
        step();

        // Unity gain, equal channels
        drive(1'b1, 16'h4000, 16'h4000, acc);
        expect_tick("unity", 1'b0, 16'hC000);

        // Extreme opposite channels, then half gain
        drive(1'b1, 16'h8000, 16'h7FFF, acc);
        idle(3);
        volume = 4'd7;
        drive(1'b1, 16'h2000, 16'h2000, acc);
        idle(3);
        volume = 4'd15;
        expect_tick("extreme", 1'b0, 16'h7FFF);
        expect_tick("halfgain", 1'b0, 16'h9000);

        // Single sample then starvation
        drive(1'b1, 16'h4000, 16'h4000, acc);
        expect_tick("last", 1'b0, 16'hC000);
        expect_tick("starve", 1'b1, UNDER_OUT);

        // Stage-2 write lands on the boundary-decision cycle with an empty FIFO
        wait_pos(int'(FRAME_LEN) - 3);
        drive(1'b1, 16'h1234, 16'h0F00, acc);
        expect_tick("race_under", 1'b1, UNDER_OUT);
        expect_tick("race_next", 1'b0, 16'h909A);

        // Mid-frame reset discards buffered samples
        for (int i = 0; i < 5; i++) drive(1'b1, 16'($urandom), 16'($urandom), acc);
        wait_pos(300);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_sample", 32'(sample_out), 32'h8000);
        chk("midreset_ready", 32'(in_ready), 32'd1);
        step();
        expect_tick("midreset_under", 1'b1, 16'h8000);

        // Back-pressure: exactly FIFO_DEPTH accepts without pops
        do_reset(1);
        n_acc = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), acc);
            n_acc += int'(acc);
        end
        chk("flood_accepts", 32'(n_acc), 32'(FIFO_DEPTH));
        in_valid = 1'b0;
        @(negedge clk);
        chk("flood_full_ready", 32'(in_ready), 32'd0);
        step();
        seek_tick("flood_pop", seen);
        if (seen) chk("flood_ready_after_pop", 32'(in_ready), 32'd1);
        step();
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            seek_tick("flood_drain", seen);
            step();
        end

        // Random bursts; volume only changes while the pipeline is idle
        for (int b = 0; b < 12; b++) begin
            idle(3);
            volume = 4'($urandom_range(0, 15));
            for (int i = 0; i < int'($urandom_range(1, 300)); i++) begin
                drive(1'($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), acc);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (sb.size() == 0) break;
            seek_tick("drain", seen);
            step();
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
